// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table and output polarities.
// Everything driving the display pins is active-low.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;
  localparam logic DP_ON  = 1'b0;
  localparam logic DP_OFF = 1'b1;

  // Segment order is {g,f,e,d,c,b,a}; a zero lights the segment.
  localparam seg_t HEX_SEG [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic seg_t hex_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
// Zero latency; no flow control.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_seg(nibble);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex 7-segment driver with per-slot anode blanking and per-frame input snapshot.
// Outputs registered one cycle after the selecting state; SEG_LZB_EN enables leading-zero blanking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         blank_cnt;
  logic [4*DIGITS-1:0]   shadow_val;
  logic [DIGITS-1:0]     shadow_dp;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nibble;
  logic                  dp_sel;
  logic [6:0]            seg_dec;
  logic [6:0]            seg_nxt;
  logic [DIGITS-1:0]     an_nxt;

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      blank_cnt   <= BW'(BLANK_CYCLES);
      shadow_val  <= '0;
      shadow_dp   <= '0;
      frame_start <= 1'b0;
    end else begin
      if (tick) begin
        presc     <= '0;
        idx       <= wrap ? '0 : idx + 1'b1;
        blank_cnt <= BW'(BLANK_CYCLES);
      end else begin
        presc <= presc + 1'b1;
        if (blank_cnt != '0) begin
          blank_cnt <= blank_cnt - 1'b1;
        end
      end
      // The snapshot only moves at frame wrap so a mid-frame count change cannot tear the display.
      if (wrap) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      frame_start <= wrap;
    end
  end

  always_comb begin
    nibble = '0;
    dp_sel = 1'b0;
    an_nxt = {DIGITS{AN_OFF}};
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nibble = shadow_val[4*i +: 4];
        dp_sel = shadow_dp[i];
        if (blank_cnt == '0) begin
          an_nxt[i] = AN_ON;
        end
      end
    end
  end

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SEG_LZB_EN
  logic [DIGITS-1:0] lz_show;

  // A digit is shown if it or any more significant nibble is nonzero; digit 0 always shows.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    lz_show = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen       = seen | (shadow_val[4*i +: 4] != 4'h0);
      lz_show[i] = seen || (i == 0);
    end
  end

  always_comb begin
    seg_nxt = SEG_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i) && lz_show[i]) begin
        seg_nxt = seg_dec;
      end
    end
  end
`else
  assign seg_nxt = seg_dec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {DIGITS{AN_OFF}};
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_sel ? DP_ON : DP_OFF;
    end
  end

endmodule
